seg7_scanner: RTL

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 40 ++++
 rtl/seg7_scanner.sv | 118 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: digit count, active-low glyphs
// ordered {g,f,e,d,c,b,a}, and the anode-select helper.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Active-low one-hot anode pattern for a digit index
  function automatic logic [NUM_DIGITS-1:0] anode_mask(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] mask;
    mask      = {NUM_DIGITS{1'b1}};
    mask[idx] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low 7-segment glyph; with HEX_MODE=0 values above 9
// collapse to a single dash.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = GLYPH_BLANK;
    if ((HEX_MODE == 0) && (digit > 4'd9)) begin
      seg = GLYPH_DASH;
    end else begin
      case (digit)
        4'h0:    seg = GLYPH_0;
        4'h1:    seg = GLYPH_1;
        4'h2:    seg = GLYPH_2;
        4'h3:    seg = GLYPH_3;
        4'h4:    seg = GLYPH_4;
        4'h5:    seg = GLYPH_5;
        4'h6:    seg = GLYPH_6;
        4'h7:    seg = GLYPH_7;
        4'h8:    seg = GLYPH_8;
        4'h9:    seg = GLYPH_9;
        4'hA:    seg = GLYPH_A;
        4'hB:    seg = GLYPH_B;
        4'hC:    seg = GLYPH_C;
        4'hD:    seg = GLYPH_D;
        4'hE:    seg = GLYPH_E;
        4'hF:    seg = GLYPH_F;
        default: seg = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit multiplexed 7-segment driver: frame-aligned shadowing of value/dp,
// optional leading-zero blanking, registered active-low outputs.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk500hz,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  logic        prev_r;
  logic [1:0]  idx_r;
  logic [15:0] shadow_r;
  logic [3:0]  shadow_dp_r;
  logic [3:0]  an_r;
  logic [6:0]  seg_r;
  logic        dp_r;
  logic        frame_done_r;

  logic        adv_s;
  logic        wrap_s;
  logic        blank_s;
  logic [3:0]  digit_s;
  logic [6:0]  glyph_s;

  // prev keeps tracking while disabled, so re-enabling on a high strobe is not a tick
  assign adv_s  = clk500hz & ~prev_r & enable;
  assign wrap_s = adv_s & (idx_r == 2'd3);

  // Active digit select and leading-zero blank decision
  always_comb begin
    digit_s = 4'h0;
    blank_s = 1'b0;
    case (idx_r)
      2'd0: begin
        digit_s = shadow_r[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        digit_s = shadow_r[7:4];
        blank_s = blank_lz & (shadow_r[15:4] == 12'h000);
      end
      2'd2: begin
        digit_s = shadow_r[11:8];
        blank_s = blank_lz & (shadow_r[15:8] == 8'h00);
      end
      2'd3: begin
        digit_s = shadow_r[15:12];
        blank_s = blank_lz & (shadow_r[15:12] == 4'h0);
      end
      default: begin
        digit_s = 4'h0;
        blank_s = 1'b0;
      end
    endcase
  end

  seg7_decode #(
    .HEX_MODE(HEX_MODE)
  ) u_decode (
    .digit(digit_s),
    .seg  (glyph_s)
  );

  // Scan state: strobe edge detector, digit index, shadow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r       <= 1'b0;
      idx_r        <= 2'd0;
      shadow_r     <= 16'h0000;
      shadow_dp_r  <= 4'h0;
      frame_done_r <= 1'b0;
    end else begin
      prev_r       <= clk500hz;
      frame_done_r <= wrap_s;
      if (adv_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (wrap_s) begin
        shadow_r    <= value;
        shadow_dp_r <= dp_in;
      end
    end
  end

  // Output registers; disabled or blanked digits drive everything off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_r  <= 4'hF;
      seg_r <= GLYPH_BLANK;
      dp_r  <= 1'b1;
    end else if (!enable) begin
      an_r  <= 4'hF;
      seg_r <= GLYPH_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= anode_mask(idx_r);
      seg_r <= blank_s ? GLYPH_BLANK : glyph_s;
      dp_r  <= blank_s | ~shadow_dp_r[idx_r];
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_done = frame_done_r;

endmodule
